// File: rtl/cflog_writer.sv
// cflog_writer: turns control-flow transfers and completed-loop summaries
// into 16-bit words written sequentially into the CF-Log region of TCB
// memory. Events are buffered in a small FIFO. When the log fills, the
// block requests a flush and waits for the TCB to acknowledge it.
module cflog_writer #(
    parameter logic [15:0] LOG_BASE   = 16'hE000,
    parameter int unsigned LOG_WORDS  = 256,
    parameter int unsigned CTR_SIZE   = 32,
    parameter logic [15:0] LOOP_TAG   = 16'hFFFF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         hw_wr_en,
    input  logic [15:0]                  prev_pc,
    input  logic [15:0]                  pc,
    input  logic                         loop_detect,
    input  logic [CTR_SIZE-1:0]          loop_ctr,
    input  logic                         flush_ack,
    output logic                         log_wen,
    output logic [15:0]                  log_addr,
    output logic [15:0]                  log_data,
    output logic [$clog2(LOG_WORDS):0]   log_ptr,
    output logic                         flush_req,
    output logic                         overflow
);

    localparam int unsigned PW = $clog2(LOG_WORDS) + 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WR_A, S_WR_B, S_FULL} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] ptr;
    logic          ptr_inc;
    logic          pop;

    logic [15:0]   fifo_a [FIFO_DEPTH];
    logic [15:0]   fifo_b [FIFO_DEPTH];
    logic [AW-1:0] wr_idx, rd_idx, br_idx;
    logic [AW:0]   count, free_slots, n_push;

    logic          ld_q;
    logic [15:0]   lat_ctr;
    logic          loop_end, branch, push_loop, push_br, drop;

    // Only the low 16 bits of the loop counter are ever logged.
    logic          ctr_unused;
    assign ctr_unused = ^loop_ctr;

    assign loop_end   = ld_q && !loop_detect;
    assign branch     = hw_wr_en && !loop_detect;
    assign free_slots = (AW+1)'(FIFO_DEPTH) - count;
    // Loop record has priority; a coincident branch needs a second free slot.
    assign push_loop  = loop_end && (free_slots != '0);
    assign push_br    = branch && (push_loop ? (free_slots >= (AW+1)'(2))
                                             : (free_slots != '0));
    assign drop       = (loop_end && !push_loop) || (branch && !push_br);
    assign n_push     = (AW+1)'(push_loop) + (AW+1)'(push_br);
    assign br_idx     = push_loop ? wr_idx + AW'(1) : wr_idx;

    assign log_ptr    = ptr;
    assign log_addr   = LOG_BASE + 16'({ptr, 1'b0});

    // Loop-end detection and capture of the counter before loop_monitor clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_q    <= 1'b0;
            lat_ctr <= '0;
        end else begin
            ld_q <= loop_detect;
            if (loop_detect)
                lat_ctr <= loop_ctr[15:0];
        end
    end

    // FIFO payload storage; contents are meaningless while count is zero.
    always_ff @(posedge clk) begin
        if (push_loop) begin
            fifo_a[wr_idx] <= LOOP_TAG;
            fifo_b[wr_idx] <= lat_ctr;
        end
        if (push_br) begin
            fifo_a[br_idx] <= prev_pc;
            fifo_b[br_idx] <= pc;
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_idx   <= '0;
            rd_idx   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_idx <= wr_idx + AW'(n_push);
            if (pop)
                rd_idx <= rd_idx + AW'(1);
            count <= count + n_push - (AW+1)'(pop);
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Drain FSM state, log pointer and flush request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            ptr       <= '0;
            flush_req <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_req <= (state == S_FULL) && !flush_ack;
            if (state == S_FULL && flush_ack)
                ptr <= '0;
            else if (ptr_inc)
                ptr <= ptr + PW'(1);
        end
    end

    // Next-state and write-port outputs; a record starts only when both words fit.
    always_comb begin
        state_nxt = state;
        log_wen   = 1'b0;
        log_data  = '0;
        ptr_inc   = 1'b0;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0)
                    state_nxt = (ptr <= PW'(LOG_WORDS - 2)) ? S_WR_A : S_FULL;
            end
            S_WR_A: begin
                log_wen   = 1'b1;
                log_data  = fifo_a[rd_idx];
                ptr_inc   = 1'b1;
                state_nxt = S_WR_B;
            end
            S_WR_B: begin
                log_wen  = 1'b1;
                log_data = fifo_b[rd_idx];
                ptr_inc  = 1'b1;
                pop      = 1'b1;
                if (count > (AW+1)'(1))
                    state_nxt = (ptr + PW'(1) <= PW'(LOG_WORDS - 2)) ? S_WR_A : S_FULL;
                else
                    state_nxt = S_IDLE;
            end
            S_FULL: begin
                if (flush_ack)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cflog_writer.sv
// Directed testbench for cflog_writer with an 8-word log so that the
// fill, flush and overflow paths are reachable in a few cycles.
module tb_cflog_writer;

    localparam int unsigned LW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        hw_wr_en;
    logic [15:0] prev_pc, pc;
    logic        loop_detect;
    logic [31:0] loop_ctr;
    logic        flush_ack;
    logic        log_wen;
    logic [15:0] log_addr, log_data;
    logic [3:0]  log_ptr;
    logic        flush_req, overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t0;

    logic [15:0] qa[$];
    logic [15:0] qd[$];
    int          qc[$];

    cflog_writer #(.LOG_WORDS(LW)) dut (
        .clk(clk), .reset(reset), .hw_wr_en(hw_wr_en), .prev_pc(prev_pc),
        .pc(pc), .loop_detect(loop_detect), .loop_ctr(loop_ctr),
        .flush_ack(flush_ack), .log_wen(log_wen), .log_addr(log_addr),
        .log_data(log_data), .log_ptr(log_ptr), .flush_req(flush_req),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every word written, with the cycle it appeared in.
    always @(negedge clk) begin
        if (!reset && log_wen) begin
            qa.push_back(log_addr);
            qd.push_back(log_data);
            qc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic clear_q();
        qa.delete();
        qd.delete();
        qc.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        hw_wr_en = 1'b0;
        loop_detect = 1'b0;
        loop_ctr = '0;
        flush_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_q();
    endtask

    task automatic branch(input logic [15:0] s, input logic [15:0] d);
        @(negedge clk);
        hw_wr_en = 1'b1;
        prev_pc = s;
        pc = d;
        @(negedge clk);
        hw_wr_en = 1'b0;
    endtask

    task automatic wait_words(input int n, input string tag);
        int k = 0;
        while (qd.size() < n && k < 60) begin
            @(negedge clk);
            #1 k++;
        end
        chk(tag, qd.size(), n);
    endtask

    task automatic wait_flush(input string tag);
        int k = 0;
        while (!flush_req && k < 20) begin
            @(negedge clk);
            #1 k++;
        end
        chk(tag, flush_req, 1);
    endtask

    task automatic ack();
        @(negedge clk);
        flush_ack = 1'b1;
        @(negedge clk);
        flush_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        hw_wr_en = 1'b0;
        prev_pc = '0;
        pc = '0;
        loop_detect = 1'b0;
        loop_ctr = '0;
        flush_ack = 1'b0;
        #1;
        chk("rst_wen", log_wen, 0);
        chk("rst_addr", log_addr, 16'hE000);
        chk("rst_data", log_data, 0);
        chk("rst_ptr", log_ptr, 0);
        chk("rst_freq", flush_req, 0);
        chk("rst_ovf", overflow, 0);
        do_reset();

        // Single branch, including first-word latency.
        @(negedge clk);
        hw_wr_en = 1'b1;
        prev_pc = 16'h1234;
        pc = 16'h5678;
        @(posedge clk);
        #1 t0 = cyc;
        @(negedge clk);
        hw_wr_en = 1'b0;
        wait_words(2, "br_cnt");
        repeat (2) @(negedge clk);
        chk("br_d0", qd[0], 16'h1234);
        chk("br_a0", qa[0], 16'hE000);
        chk("br_d1", qd[1], 16'h5678);
        chk("br_a1", qa[1], 16'hE002);
        chk("br_latA", qc[0] - t0, 1);
        chk("br_latB", qc[1] - qc[0], 1);
        chk("br_ptr", log_ptr, 2);

        // Branch, then counted loop; iteration branches must not be logged.
        do_reset();
        branch(16'h0100, 16'h0200);
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            hw_wr_en = 1'b1;
            loop_detect = 1'b1;
            loop_ctr = (k == 7) ? 32'h5A5A_0007 : 32'(k);
        end
        @(negedge clk);
        hw_wr_en = 1'b0;
        loop_detect = 1'b0;
        loop_ctr = 32'd1;
        wait_words(4, "lp_cnt");
        repeat (6) @(negedge clk);
        chk("lp_only4", qd.size(), 4);
        chk("lp_d0", qd[0], 16'h0100);
        chk("lp_d1", qd[1], 16'h0200);
        chk("lp_d2", qd[2], 16'hFFFF);
        chk("lp_d3", qd[3], 16'h0007);
        chk("lp_a3", qa[3], 16'hE006);

        // Loop end and branch in the same cycle: loop record first, back to back.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            loop_detect = 1'b1;
            loop_ctr = 32'd3;
        end
        @(negedge clk);
        loop_detect = 1'b0;
        loop_ctr = 32'd1;
        hw_wr_en = 1'b1;
        prev_pc = 16'h0A0A;
        pc = 16'h0B0B;
        @(negedge clk);
        hw_wr_en = 1'b0;
        wait_words(4, "sim_cnt");
        chk("sim_d0", qd[0], 16'hFFFF);
        chk("sim_d1", qd[1], 16'h0003);
        chk("sim_d2", qd[2], 16'h0A0A);
        chk("sim_d3", qd[3], 16'h0B0B);
        chk("sim_span", qc[3] - qc[0], 3);
        chk("sim_ovf", overflow, 0);

        // Fill an 8-word log with five branches; the fifth waits for the flush.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            branch(16'h1000 + 16'(i), 16'h2000 + 16'(i));
            repeat (3) @(negedge clk);
        end
        wait_flush("fill_freq");
        chk("fill_ptr", log_ptr, 8);
        chk("fill_words", qd.size(), 8);
        chk("fill_d7", qd[7], 16'h2003);
        chk("fill_a7", qa[7], 16'hE00E);
        ack();
        #1 chk("fill_freq_lo", flush_req, 0);
        wait_words(10, "fill_post");
        chk("fill_d8", qd[8], 16'h1004);
        chk("fill_a8", qa[8], 16'hE000);
        chk("fill_d9", qd[9], 16'h2004);
        @(negedge clk);
        chk("fill_ptr2", log_ptr, 2);

        // Overflow: log full, then FIFO_DEPTH+1 branches in consecutive cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            branch(16'h3000 + 16'(i), 16'h4000 + 16'(i));
            repeat (3) @(negedge clk);
        end
        wait_words(8, "ovf_pre");
        chk("ovf_pre_flag", overflow, 0);
        clear_q();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            hw_wr_en = 1'b1;
            prev_pc = 16'h5000 + 16'(i);
            pc = 16'h6000 + 16'(i);
        end
        @(negedge clk);
        hw_wr_en = 1'b0;
        #1 chk("ovf_flag", overflow, 1);
        wait_flush("ovf_freq");
        chk("ovf_held", qd.size(), 0);
        ack();
        wait_words(8, "ovf_post");
        repeat (6) @(negedge clk);
        chk("ovf_only8", qd.size(), 8);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_src", qd[2*i], 16'h5000 + 16'(i));
            chk("ovf_dst", qd[2*i+1], 16'h6000 + 16'(i));
        end
        chk("ovf_a0", qa[0], 16'hE000);

        // Reset asserted while the second word is on the bus.
        do_reset();
        chk("rr_ovf_clr", overflow, 0);
        branch(16'hAAAA, 16'hBBBB);
        begin
            int k = 0;
            while (qd.size() < 2 && k < 20) begin
                @(negedge clk);
                #1 k++;
            end
        end
        chk("rr_seen_b", qd.size(), 2);
        chk("rr_wen_b", log_wen, 1);
        reset = 1'b1;
        #1;
        chk("rr_wen", log_wen, 0);
        chk("rr_ptr", log_ptr, 0);
        chk("rr_addr", log_addr, 16'hE000);
        chk("rr_data", log_data, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("rr_nomore", qd.size(), 2);
        branch(16'h1111, 16'h2222);
        wait_words(4, "rr_post");
        chk("rr_d2", qd[2], 16'h1111);
        chk("rr_a2", qa[2], 16'hE000);
        chk("rr_a3", qa[3], 16'hE002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cflog_writer.md
# cflog_writer

Control-flow log writer placed directly downstream of `loop_monitor` in the CFA hardware. It turns logged control-flow transfers (`hw_wr_en`, `prev_pc`, `pc`) and completed-loop summaries (`loop_detect`, `loop_ctr`) into 16-bit words written sequentially into the CF-Log region of TCB memory. A small event FIFO absorbs bursts. When the log region fills, the block raises `flush_req` toward the TCB/NMI logic and stalls until the TCB acknowledges.

## Interface
Parameters:
- `LOG_BASE`, default 16'hE000: byte address of CF-Log word 0.
- `LOG_WORDS`, default 256: log capacity in 16-bit words. Must be even and ≥4.
- `CTR_SIZE`, default 32: width of `loop_ctr`.
- `LOOP_TAG`, default 16'hFFFF: first word of a loop record.
- `FIFO_DEPTH`, default 4: event FIFO entries. Must be a power of two, ≥2.

Ports:
- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `hw_wr_en`, input, 1: a control-flow transfer must be logged this cycle.
- `prev_pc`, input, 16: transfer source.
- `pc`, input, 16: transfer destination.
- `loop_detect`, input, 1: a loop is currently being counted.
- `loop_ctr`, input, CTR_SIZE: current iteration count.
- `flush_ack`, input, 1: one-cycle pulse from the TCB meaning the log has been consumed.
- `log_wen`, output, 1: write strobe, one word per cycle.
- `log_addr`, output, 16: equal to `LOG_BASE + 2*ptr`.
- `log_data`, output, 16: word to write.
- `log_ptr`, output, clog2(LOG_WORDS)+1: number of words written since the last reset or flush.
- `flush_req`, output, 1: log full; held high until `flush_ack`.
- `overflow`, output, 1: sticky flag; set when an event is dropped because the FIFO is full. Cleared only by reset.

## Operation
- Events are pushed into the FIFO. Each FIFO entry holds {type, wordA, wordB}.
  - Branch event: pushed when `hw_wr_en=1` and `loop_detect=0`. wordA=`prev_pc`, wordB=`pc`.
  - Loop-iteration branch: `hw_wr_en=1` while `loop_detect=1`. It is dropped and not logged, because `loop_monitor` is counting it.
  - Loop record: pushed on a falling edge of `loop_detect` (registered previous value 1, current 0). wordA=`LOOP_TAG`, wordB=`lat_ctr[15:0]`.
- `lat_ctr` captures `loop_ctr` every cycle that `loop_detect=1`. This is required because `loop_monitor` restores its counter to CTR_MIN in the same cycle `loop_detect` falls.
- Simultaneous loop end and branch in one cycle: two pushes, loop record first, then branch. This needs ≥2 free slots.
  - With only 1 slot free, the loop record is kept, the branch is dropped, and `overflow` is set.
- FIFO full on push: the event is dropped and `overflow` is set.
- Drain FSM states:
  - IDLE: if FIFO not empty and `ptr ≤ LOG_WORDS-2`, go to WR_A. If FIFO not empty and `ptr > LOG_WORDS-2`, go to FULL.
  - WR_A: `log_wen=1`, `log_data`=wordA, `ptr+=1`, go to WR_B.
  - WR_B: `log_wen=1`, `log_data`=wordB, `ptr+=1`, pop the FIFO. Then go to WR_A if the FIFO holds another entry and there is room, to FULL if it holds another entry and there is no room, otherwise to IDLE.
  - FULL: `flush_req=1`. FIFO keeps accepting pushes. On `flush_ack`: `ptr←0`, `flush_req←0`, go to IDLE.
- A record is never split across a flush.
- `flush_ack` outside FULL is ignored.
- `ptr` arithmetic is unsigned. `ptr` never exceeds `LOG_WORDS`.
- `loop_ctr` bits above [15] are discarded.

## Timing
- Reset (asynchronous) values: `log_wen=0`, `log_addr=LOG_BASE`, `log_data=0`, `log_ptr=0`, `flush_req=0`, `overflow=0`, FIFO empty, FSM in IDLE, `lat_ctr=0`, previous-`loop_detect` register = 0.
- Reset asserted mid-record aborts the record immediately: the partial word is not completed and there is no further `log_wen`.
- Latency: event sampled at edge E, with FIFO empty and FSM in IDLE.
  - wordA: `log_wen=1` in the cycle after E+1.
  - wordB: `log_wen=1` in the next cycle.
- Back-to-back records are written with no idle cycle, giving 2 cycles per record.
- `log_addr` and `log_data` are valid whenever `log_wen=1`. Otherwise they are don't-care.
- `flush_req` rises the cycle after the FSM enters FULL and falls the cycle after `flush_ack` is sampled. Draining resumes one cycle later.
- Loop record is pushed at the edge where `loop_detect` is sampled 0 after being 1.

## Test plan
- Single branch: `prev_pc`=16'h1234, `pc`=16'h5678, `hw_wr_en` for 1 cycle → words 1234 at `LOG_BASE` and 5678 at `LOG_BASE+2`, `log_ptr`=2.
- Loop: one logged branch, then `loop_detect` high with `loop_ctr` counting 2..7 while `hw_wr_en` repeats, then falls → exactly 4 words: src, dest, FFFF, 0007.
- Fill: `LOG_WORDS`=8, five branches → 4 records written, `log_ptr`=8, `flush_req`=1, 5th record held. `flush_ack` → `log_ptr`=0, 5th record written at `LOG_BASE`.
- Simultaneous loop end and branch with FIFO empty → loop record, then branch record, in that order, 4 consecutive `log_wen` cycles.
- Overflow: FSM in FULL, `FIFO_DEPTH`+1 branches pushed → `overflow`=1, FIFO holds the first 4 events, which are written in order after `flush_ack`.
- Reset asserted during WR_B → all outputs return to reset values asynchronously. After release, the next branch is written at `LOG_BASE`.
